// File: rtl/cpu_pkg.sv
// Shared DECA CPU constants: opcodes and the one-hot sequencer state encoding,
// used by the sequencer, decode and the benches.
package cpu_pkg;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JMI = 4'd5;
  localparam logic [3:0] OP_JEQ = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;
  localparam logic [3:0] OP_LDI = 4'd8;
  localparam logic [3:0] OP_LSR = 4'd10;
  localparam logic [3:0] OP_ASR = 4'd11;

  typedef enum logic [3:0] {
    ST_FETCH = 4'b0001,
    ST_EXEC1 = 4'b0010,
    ST_EXEC2 = 4'b0100,
    ST_HALT  = 4'b1000
  } state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer bus: control inputs from run logic, RAM and decode, plus the
// state/IR outputs consumed by decode and the datapath.
interface cpu_sequencer_if #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 16
);
  logic              run;
  logic [WORD_W-1:0] mem_q;
  logic              EXTRA;
  logic              P;
  logic              FETCH;
  logic              EXEC1;
  logic              EXEC2;
  logic [3:0]        IR;
  logic [WORD_W-5:0] N;
  logic              BeenPipelined;
  logic              ir_load;
  logic              halted;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    output run, mem_q, EXTRA, P,
    input  FETCH, EXEC1, EXEC2, IR, N, BeenPipelined, ir_load, halted, instr_count
  );

  modport slave (
    input  run, mem_q, EXTRA, P,
    output FETCH, EXEC1, EXEC2, IR, N, BeenPipelined, ir_load, halted, instr_count
  );
endinterface

// File: rtl/cpu_sequencer_instr_reg.sv
// Instruction register: opcode and operand fields captured from RAM read data
// on the edge that closes an instruction-load cycle.
module instr_reg #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] d,
  output logic [3:0]        ir,
  output logic [WORD_W-5:0] n
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= '0;
      n  <= '0;
    end else if (load) begin
      ir <= d[WORD_W-1 -: 4];
      n  <= d[WORD_W-5:0];
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// DECA CPU instruction sequencer: FETCH/EXEC1/EXEC2/HALT FSM, IR/N register
// and retired-load counter. Fetch/execute overlap is built when CPU_SEQ_PIPELINE_EN is defined.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             reset,
  cpu_sequencer_if.slave  bus
);

  state_t           state_reg, state_next;
  logic             ir_load;
  logic             final_cycle;
  logic [3:0]       ir;
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    ir_load     = 1'b0;
    final_cycle = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        if (bus.run) begin
          ir_load    = 1'b1;
          state_next = ST_EXEC1;
        end
      end
      ST_EXEC1: begin
        // STP wins even if decode also requests EXEC2
        if (ir == OP_STP)   state_next = ST_HALT;
        else if (bus.EXTRA) state_next = ST_EXEC2;
        else                final_cycle = 1'b1;
      end
      ST_EXEC2: final_cycle = 1'b1;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_FETCH;
    endcase
    if (final_cycle) begin
`ifdef CPU_SEQ_PIPELINE_EN
      if (bus.P && bus.run) begin
        ir_load    = 1'b1;
        state_next = ST_EXEC1;
      end else begin
        state_next = ST_FETCH;
      end
`else
      state_next = ST_FETCH;
`endif
    end
  end

`ifdef CPU_SEQ_PIPELINE_EN
  logic bp_reg;

  // A load issued from any state other than FETCH is an overlapped one
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bp_reg <= 1'b0;
    else if (ir_load)
      bp_reg <= (state_reg != ST_FETCH);
    else if (state_next == ST_FETCH)
      bp_reg <= 1'b0;
  end

  assign bus.BeenPipelined = bp_reg;
`else
  assign bus.BeenPipelined = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        count_reg <= '0;
    else if (ir_load) count_reg <= count_reg + 1'b1;
  end

  instr_reg #(.WORD_W(WORD_W)) u_instr_reg (
    .clk   (clk),
    .reset (reset),
    .load  (ir_load),
    .d     (bus.mem_q),
    .ir    (ir),
    .n     (bus.N)
  );

  assign bus.IR          = ir;
  assign bus.ir_load     = ir_load;
  assign bus.FETCH       = (state_reg == ST_FETCH);
  assign bus.EXEC1       = (state_reg == ST_EXEC1);
  assign bus.EXEC2       = (state_reg == ST_EXEC2);
  assign bus.halted      = (state_reg == ST_HALT);
  assign bus.instr_count = count_reg;

endmodule
